// File: rtl/regfile_access_sequencer_if.sv
// rtl/regfile_access_sequencer_if.sv - request, register file and execute-unit signals of the access sequencer
`timescale 1ns/1ps
interface regfile_access_sequencer_if #(
   parameter int W = 16
);
   logic         req_valid;
   logic         req_ready;
   logic [2:0]   req_rd;
   logic [2:0]   req_rn;
   logic [2:0]   req_rm;
   logic         req_wb;
   logic [2:0]   rf_readnum;
   logic [W-1:0] rf_data_out;
   logic [2:0]   rf_writenum;
   logic         rf_write;
   logic [W-1:0] rf_data_in;
   logic [W-1:0] exe_a;
   logic [W-1:0] exe_b;
   logic         exe_valid;
   logic [W-1:0] exe_result;
   logic         exe_done;
   logic         done;
   logic [W-1:0] result;
   logic         timeout_err;

   modport master (
      input  req_valid, req_rd, req_rn, req_rm, req_wb, rf_data_out, exe_result, exe_done,
      output req_ready, rf_readnum, rf_writenum, rf_write, rf_data_in,
             exe_a, exe_b, exe_valid, done, result, timeout_err
   );

   modport slave (
      output req_valid, req_rd, req_rn, req_rm, req_wb, rf_data_out, exe_result, exe_done,
      input  req_ready, rf_readnum, rf_writenum, rf_write, rf_data_in,
             exe_a, exe_b, exe_valid, done, result, timeout_err
   );
endinterface

// File: rtl/regfile_access_sequencer.sv
// rtl/regfile_access_sequencer.sv - sequences Rn/Rm reads, execute handshake and Rd write-back
`timescale 1ns/1ps
module regfile_access_sequencer #(
   parameter int W       = 16,
   parameter int TIMEOUT = 15
) (
   input  logic                            clk,
   input  logic                            reset_n,
   regfile_access_sequencer_if.master      bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ_A,
      S_READ_B,
      S_EXEC,
      S_WRITE
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t       state_q, state_d;
   logic [2:0]   rd_q, rd_d;
   logic [2:0]   rn_q, rn_d;
   logic [2:0]   rm_q, rm_d;
   logic         wb_q, wb_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [W-1:0] exe_a_q, exe_a_d;
   logic [W-1:0] exe_b_q, exe_b_d;
   logic [W-1:0] result_q, result_d;
   logic         done_q, done_d;
   logic         timeout_q, timeout_d;

   logic         req_ready_c;
   logic [2:0]   rf_readnum_c;
   logic         rf_write_c;
   logic [2:0]   rf_writenum_c;
   logic [W-1:0] rf_data_in_c;
   logic         exe_valid_c;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         rd_q      <= '0;
         rn_q      <= '0;
         rm_q      <= '0;
         wb_q      <= 1'b0;
         cnt_q     <= '0;
         exe_a_q   <= '0;
         exe_b_q   <= '0;
         result_q  <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_q      <= rd_d;
         rn_q      <= rn_d;
         rm_q      <= rm_d;
         wb_q      <= wb_d;
         cnt_q     <= cnt_d;
         exe_a_q   <= exe_a_d;
         exe_b_q   <= exe_b_d;
         result_q  <= result_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      rd_d          = rd_q;
      rn_d          = rn_q;
      rm_d          = rm_q;
      wb_d          = wb_q;
      cnt_d         = cnt_q;
      exe_a_d       = exe_a_q;
      exe_b_d       = exe_b_q;
      result_d      = result_q;
      done_d        = 1'b0;
      timeout_d     = 1'b0;
      req_ready_c   = 1'b0;
      rf_readnum_c  = '0;
      rf_write_c    = 1'b0;
      rf_writenum_c = '0;
      rf_data_in_c  = '0;
      exe_valid_c   = 1'b0;

      case (state_q)
         S_IDLE: begin
            req_ready_c = 1'b1;
            if (bus.req_valid) begin
               rd_d    = bus.req_rd;
               rn_d    = bus.req_rn;
               rm_d    = bus.req_rm;
               wb_d    = bus.req_wb;
               state_d = S_READ_A;
            end
         end
         S_READ_A: begin
            rf_readnum_c = rn_q;
            exe_a_d      = bus.rf_data_out;
            state_d      = S_READ_B;
         end
         S_READ_B: begin
            rf_readnum_c = rm_q;
            exe_b_d      = bus.rf_data_out;
            cnt_d        = '0;
            state_d      = S_EXEC;
         end
         S_EXEC: begin
            exe_valid_c = 1'b1;
            // exe_done is checked first so a result on the final allowed cycle beats the timeout
            if (bus.exe_done) begin
               result_d = bus.exe_result;
               if (wb_q) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d   = S_IDLE;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_WRITE: begin
            rf_write_c    = 1'b1;
            rf_writenum_c = rd_q;
            rf_data_in_c  = result_q;
            state_d       = S_IDLE;
            done_d        = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // rf_write decodes straight from the async-reset state register, so reset kills it without an edge
   assign bus.req_ready   = req_ready_c;
   assign bus.rf_readnum  = rf_readnum_c;
   assign bus.rf_write    = rf_write_c;
   assign bus.rf_writenum = rf_writenum_c;
   assign bus.rf_data_in  = rf_data_in_c;
   assign bus.exe_valid   = exe_valid_c;
   assign bus.exe_a       = exe_a_q;
   assign bus.exe_b       = exe_b_q;
   assign bus.result      = result_q;
   assign bus.done        = done_q;
   assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// tb/tb_regfile_access_sequencer.sv - randomized self-checking bench with register file and execute-unit model
`timescale 1ns/1ps
module tb_regfile_access_sequencer;
   localparam int TO = 15;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   regfile_access_sequencer_if #(.W(16)) bus ();

   regfile_access_sequencer #(.W(16), .TIMEOUT(TO)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // register file the sequencer talks to; pre_* loads initial contents
   logic [15:0] rf [8];
   logic        pre_we = 1'b0;
   logic [2:0]  pre_idx = '0;
   logic [15:0] pre_data = '0;
   always @(posedge clk) begin
      if (bus.rf_write) rf[bus.rf_writenum] <= bus.rf_data_in;
      else if (pre_we)  rf[pre_idx] <= pre_data;
   end
   assign bus.rf_data_out = rf[bus.rf_readnum];

   logic [15:0] mref [8];
   logic [15:0] last_res;
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic pre_write(input logic [2:0] idx, input logic [15:0] data);
      @(negedge clk);
      pre_we = 1'b1; pre_idx = idx; pre_data = data;
      @(negedge clk);
      pre_we = 1'b0;
      mref[idx] = data;
   endtask

   // delay: EXEC cycle (1-based) on which exe_done is given; 0 = never
   task automatic run_txn(input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm,
                          input logic wb, input int delay, input logic [15:0] val,
                          input bit presented, input bit chain,
                          input logic [2:0] nrd, input logic [2:0] nrn, input logic [2:0] nrm,
                          input logic nwb);
      logic [15:0] ea, eb, a_seen, b_seen;
      int cyc, ev, wr, wbad, a_bad, b_bad, done_cnt, done_cyc, to_cnt, to_cyc, rdy_bad;
      bit ok, fin;
      ea = mref[rn]; eb = mref[rm];
      ok = (delay >= 1) && (delay <= TO);
      ev = 0; wr = 0; wbad = 0; a_bad = 0; b_bad = 0; rdy_bad = 0;
      done_cnt = 0; done_cyc = 0; to_cnt = 0; to_cyc = 0;
      a_seen = '0; b_seen = '0;
      if (!presented) begin
         bus.req_rd = rd; bus.req_rn = rn; bus.req_rm = rm; bus.req_wb = wb;
         bus.req_valid = 1'b1;
      end
      check_eq("accept_ready", bus.req_ready, 1);
      @(negedge clk);
      if (chain) begin
         bus.req_rd = nrd; bus.req_rn = nrn; bus.req_rm = nrm; bus.req_wb = nwb;
      end else begin
         bus.req_valid = 1'b0;
      end
      cyc = 1; fin = 1'b0;
      while (!fin && cyc <= 40) begin
         if (bus.exe_valid) begin
            ev++;
            if (ev == 1) begin a_seen = bus.exe_a; b_seen = bus.exe_b; end
            if (bus.exe_a !== ea) a_bad++;
            if (bus.exe_b !== eb) b_bad++;
            bus.exe_done   = (ev == delay);
            bus.exe_result = (ev == delay) ? val : 16'($urandom);
         end else begin
            bus.exe_done   = 1'($urandom_range(0, 1));
            bus.exe_result = 16'($urandom);
         end
         if (bus.rf_write) begin
            wr++;
            if (bus.rf_writenum !== rd || bus.rf_data_in !== val) wbad++;
         end
         if (bus.done)        begin done_cnt++; done_cyc = cyc; fin = 1'b1; end
         if (bus.timeout_err) begin to_cnt++;   to_cyc = cyc;   fin = 1'b1; end
         if (!fin && bus.req_ready) rdy_bad++;
         if (!fin) begin @(negedge clk); cyc++; end
      end
      bus.exe_done = 1'b0;
      check_eq("exe_a", a_seen, ea);
      check_eq("exe_b", b_seen, eb);
      check_eq("exe_ab_stable", a_bad + b_bad, 0);
      check_eq("busy_not_ready", rdy_bad, 0);
      if (ok) begin
         check_eq("done_latency", done_cyc, 3 + delay + int'(wb));
         check_eq("no_timeout", to_cnt, 0);
         check_eq("exec_cycles", ev, delay);
         check_eq("write_count", wr, int'(wb));
         check_eq("write_fields", wbad, 0);
         last_res = val;
         if (wb) mref[rd] = val;
      end else begin
         check_eq("timeout_latency", to_cyc, TO + 3);
         check_eq("no_done", done_cnt, 0);
         check_eq("exec_cycles_to", ev, TO);
         check_eq("write_count_to", wr, 0);
      end
      check_eq("result", bus.result, last_res);
      check_eq("ready_after", bus.req_ready, 1);
      check_eq("rf_dest", rf[rd], mref[rd]);
   endtask

   initial begin
      logic [2:0] r_rd, r_rn, r_rm;
      logic r_wb;
      int r, dly;
      bus.req_valid = 1'b0; bus.req_rd = '0; bus.req_rn = '0; bus.req_rm = '0; bus.req_wb = 1'b0;
      bus.exe_done = 1'b0; bus.exe_result = '0;
      last_res = '0;
      #2;
      check_eq("rst_done", bus.done, 0);
      check_eq("rst_timeout", bus.timeout_err, 0);
      check_eq("rst_result", bus.result, 0);
      check_eq("rst_exe_a", bus.exe_a, 0);
      check_eq("rst_exe_b", bus.exe_b, 0);
      check_eq("rst_rf_write", bus.rf_write, 0);
      check_eq("rst_exe_valid", bus.exe_valid, 0);
      check_eq("rst_ready", bus.req_ready, 1);
      for (int i = 0; i < 8; i++) pre_write(3'(i), 16'($urandom));
      pre_write(3'd1, 16'h0005);
      pre_write(3'd2, 16'h0003);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      run_txn(3'd3, 3'd1, 3'd2, 1'b1, 1, mref[1] + mref[2], 0, 0, 0, 0, 0, 0);
      check_eq("t1_r3", rf[3], 16'h0008);
      run_txn(3'd3, 3'd1, 3'd2, 1'b0, 1, 16'h1234, 0, 0, 0, 0, 0, 0);
      check_eq("t2_r3_kept", rf[3], 16'h0008);
      run_txn(3'd5, 3'd1, 3'd2, 1'b1, 0, 16'hDEAD, 0, 0, 0, 0, 0, 0);
      run_txn(3'd6, 3'd2, 3'd1, 1'b1, TO, 16'h0F0F, 0, 0, 0, 0, 0, 0);
      run_txn(3'd4, 3'd1, 3'd2, 1'b1, 1, 16'hBEEF, 0, 1, 3'd5, 3'd4, 3'd4, 1'b1);
      run_txn(3'd5, 3'd4, 3'd4, 1'b1, 2, 16'h55AA, 1, 0, 0, 0, 0, 0);
      check_eq("b2b_r4", mref[4], 16'hBEEF);

      // reset during WRITE
      @(negedge clk);
      bus.req_rd = 3'd6; bus.req_rn = 3'd1; bus.req_rm = 3'd2; bus.req_wb = 1'b1; bus.req_valid = 1'b1;
      @(negedge clk); bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk); bus.exe_done = 1'b1; bus.exe_result = 16'h7777;
      @(negedge clk); bus.exe_done = 1'b0;
      check_eq("rst_write_seen", bus.rf_write, 1);
      #1 reset_n = 1'b0;
      #1;
      check_eq("rst_mid_rf_write", bus.rf_write, 0);
      check_eq("rst_mid_result", bus.result, 0);
      check_eq("rst_mid_exe_ab", {bus.exe_a, bus.exe_b}, 0);
      check_eq("rst_mid_flags", {bus.done, bus.timeout_err, bus.exe_valid}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check_eq("rst_rel_ready", bus.req_ready, 1);
      check_eq("rst_rel_r6", rf[6], mref[6]);
      last_res = '0;
      @(negedge clk);

      for (int t = 0; t < 40; t++) begin
         r_rd = 3'($urandom); r_rn = 3'($urandom); r_rm = 3'($urandom);
         r_wb = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 9);
         dly = (r == 0) ? 0 : (r == 1) ? TO : (r == 2) ? TO + 2 : $urandom_range(1, 4);
         run_txn(r_rd, r_rn, r_rm, r_wb, dly, 16'($urandom), 0, 0, 0, 0, 0, 0);
         if ($urandom_range(0, 2) == 0) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_access_sequencer.md
Name: regfile_access_sequencer

Overview:
- Initiator-side controller for the 8x16 register file: accepts one three-operand request (Rd, Rn, Rm) per transaction over a valid/ready handshake.
- Drives the file's read index to fetch Rn, then Rm, and presents both operands to an external execute unit.
- Waits for the result and, if requested, drives the file's write port to store it into Rd.
- Sits between instruction decode and the register file / ALU datapath.

Parameters:
- W, 16, data width; matches the register file data width.
- TIMEOUT, 15, maximum EXEC cycles to wait for exe_done before aborting. Range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_rd  in  3  destination register index.
- req_rn  in  3  first source register index.
- req_rm  in  3  second source register index.
- req_wb  in  1  1 = write result to Rd; 0 = discard result.
- rf_readnum  out  3  register file read index.
- rf_data_out  in  W  register file read data (combinational from rf_readnum).
- rf_writenum  out  3  register file write index.
- rf_write  out  1  register file write enable.
- rf_data_in  out  W  register file write data.
- exe_a  out  W  operand A (value of Rn).
- exe_b  out  W  operand B (value of Rm).
- exe_valid  out  1  operands valid; execute unit may start.
- exe_result  in  W  execute unit result.
- exe_done  in  1  result valid this cycle.
- done  out  1  one-cycle pulse: transaction completed.
- result  out  W  last captured result; held until the next completion.
- timeout_err  out  1  one-cycle pulse: EXEC timed out; transaction aborted.

Behaviour:
- Reset (reset_n=0, async) forces:
  - state=IDLE.
  - All registered outputs 0: result, exe_a, exe_b, done, timeout_err.
  - Captured indices 0; timeout counter 0.
  - rf_write=0, exe_valid=0.
- Reset asserted mid-transaction aborts it with no register file write. rf_write must drop immediately, without waiting for a clock edge.
- States: IDLE, READ_A, READ_B, EXEC, WRITE.
- IDLE:
  - req_ready=1.
  - On a clk edge with req_valid=1: capture rd/rn/rm/wb and go to READ_A.
  - The request fields are not sampled afterwards.
- READ_A:
  - rf_readnum = captured rn.
  - At the edge: exe_a <= rf_data_out; go to READ_B.
- READ_B:
  - rf_readnum = captured rm.
  - At the edge: exe_b <= rf_data_out; go to EXEC; clear the timeout counter.
- EXEC:
  - exe_valid=1 for the whole state; exe_a and exe_b held stable.
  - On an edge with exe_done=1: result <= exe_result. Then go to WRITE if wb=1; if wb=0, go to IDLE and pulse done the next cycle.
  - Otherwise the counter increments. When counter==TIMEOUT-1 with no exe_done: go to IDLE, pulse timeout_err for one cycle, result unchanged, no write.
  - exe_done on the last allowed cycle wins over the timeout.
- WRITE (exactly 1 cycle):
  - rf_write=1, rf_writenum=rd, rf_data_in=result.
  - Go to IDLE; done pulses in the following cycle.
- Outside WRITE: rf_write=0; rf_writenum and rf_data_in are don't-care but driven to 0.
- rf_readnum outside READ_A/READ_B is 0.
- req_ready=0 in every state except IDLE.
- No pipelining: one transaction in flight.
- Minimum latency, accept edge to done high:
  - 5 cycles with wb=1 and exe_done on the first EXEC cycle.
  - 4 cycles with wb=0.
- Same-register aliasing (Rn==Rm, or Rd==Rn) needs no special handling.
  - Reads complete before the write.
  - A back-to-back request reading the Rd just written sees the new value, because WRITE precedes the next READ_A by at least one cycle.
- exe_done outside EXEC is ignored.

Test Plan:
- R1=0x0005, R2=0x0003 preloaded; request rd=3, rn=1, rm=2, wb=1; execute unit returns a+b on the first EXEC cycle:
  - exe_a=0x0005, exe_b=0x0003.
  - rf_write=1 for exactly one cycle with writenum=3, data_in=0x0008.
  - done pulses 5 cycles after accept; result=0x0008.
- Same request with wb=0 and result 0x1234 -> no rf_write at any point; done after 4 cycles; result=0x1234; R3 unchanged.
- exe_done withheld, TIMEOUT=15 -> exe_valid high for 15 cycles; then timeout_err pulses once; no write; req_ready returns to 1.
- exe_done first asserted on EXEC cycle 15 (TIMEOUT=15) -> completes normally; no timeout_err.
- Back-to-back requests:
  - First writes R4=0xBEEF.
  - Second (rn=4, rm=4) is presented continuously with req_valid and accepted the cycle req_ready rises.
  - Required: exe_a=exe_b=0xBEEF.
- reset_n pulled low during WRITE -> rf_write falls without a clock edge; all outputs 0; after release, state=IDLE, req_ready=1, and R-value of the destination is not updated by the aborted write.
